// File: rtl/conv3x3_mac_pipeline.sv
// conv3x3_mac_pipeline: 3x3 signed convolution that multiplies, accumulates, biases, shifts and saturates each window to one pixel.
// Latency: 3 cycles from window acceptance to valid_out; one window per cycle.
// Backpressure: none. Windows seen while weights_ok is low are dropped silently.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   win_valid, win0..win8    window strobe and nine signed taps, row-major
//   w_load, bias_in          start a weight load and capture its bias
//   w_valid, w_data          weight beats 0..8, paired with win0..win8
//   valid_out, pix_out       output pixel strobe and value (held while idle)
//   sat_flag                 output was clipped to [-128, 127]
//   weights_ok, load_busy    a weight set has been committed / a load is in progress
// Build option: define RELU_EN to clamp negative output pixels to zero.
module conv3x3_mac_pipeline #(
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              win_valid,
    input  logic signed [7:0] win0,
    input  logic signed [7:0] win1,
    input  logic signed [7:0] win2,
    input  logic signed [7:0] win3,
    input  logic signed [7:0] win4,
    input  logic signed [7:0] win5,
    input  logic signed [7:0] win6,
    input  logic signed [7:0] win7,
    input  logic signed [7:0] win8,
    input  logic              w_load,
    input  logic signed [15:0] bias_in,
    input  logic              w_valid,
    input  logic signed [7:0] w_data,
    output logic              valid_out,
    output logic signed [7:0] pix_out,
    output logic              sat_flag,
    output logic              weights_ok,
    output logic              load_busy
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic signed [19:0] PIX_MAX = 20'sd127;
    localparam logic signed [19:0] PIX_MIN = -20'sd128;

    logic signed [7:0]  taps [9];
    logic signed [7:0]  shadow_w [9];
    logic signed [7:0]  act_w [9];
    logic signed [15:0] shadow_bias;
    logic signed [15:0] act_bias;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       beat_wr;
    logic       commit;

    assign taps[0] = win0;
    assign taps[1] = win1;
    assign taps[2] = win2;
    assign taps[3] = win3;
    assign taps[4] = win4;
    assign taps[5] = win5;
    assign taps[6] = win6;
    assign taps[7] = win7;
    assign taps[8] = win8;

    // ---------------- weight load FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fresh w_load always wins over a coincident beat; the restarted
    // sequence overwrites every shadow slot before it can commit, so the
    // stale partial shadow never needs explicit clearing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_wr = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                end
            end
            LOAD: begin
                if (w_load) begin
                    cnt_d = 4'd0;
                end else if (w_valid) begin
                    beat_wr = 1'b1;
                    if (cnt_q == 4'd8) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_busy = (state_q == LOAD);

    // The 9th beat goes straight into the active bank alongside the eight
    // shadow entries, so the commit needs no extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                shadow_w[i] <= 8'sd0;
                act_w[i]    <= 8'sd0;
            end
            shadow_bias <= 16'sd0;
            act_bias    <= 16'sd0;
            weights_ok  <= 1'b0;
        end else begin
            if (w_load) begin
                shadow_bias <= bias_in;
            end
            if (beat_wr) begin
                shadow_w[cnt_q] <= w_data;
            end
            if (commit) begin
                for (int i = 0; i < 8; i++) begin
                    act_w[i] <= shadow_w[i];
                end
                act_w[8]   <= w_data;
                act_bias   <= shadow_bias;
                weights_ok <= 1'b1;
            end
        end
    end

    // ---------------- stage 1: products ----------------
    // Bias is captured together with the weights so a commit landing while a
    // window is in stages 2/3 cannot mix banks.
    logic               accept;
    logic               v1;
    logic signed [15:0] prod1 [9];
    logic signed [15:0] bias1;

    assign accept = win_valid && weights_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            bias1 <= 16'sd0;
            for (int i = 0; i < 9; i++) begin
                prod1[i] <= 16'sd0;
            end
        end else begin
            v1 <= accept;
            if (accept) begin
                bias1 <= act_bias;
                for (int i = 0; i < 9; i++) begin
                    prod1[i] <= 16'(taps[i]) * 16'(act_w[i]);
                end
            end
        end
    end

    // ---------------- stage 2: adder tree + bias ----------------
    logic               v2;
    logic signed [19:0] sum_c;
    logic signed [19:0] sum2;

    always_comb begin
        sum_c = 20'(bias1);
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + 20'(prod1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            sum2 <= 20'sd0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sum2 <= sum_c;
            end
        end
    end

    // ---------------- stage 3: shift, saturate, optional ReLU ----------------
    logic signed [19:0] shifted;
    logic signed [7:0]  pix_c;
    logic               sat_c;

    always_comb begin
        shifted = sum2 >>> SHIFT;
        pix_c   = shifted[7:0];
        sat_c   = 1'b0;
        if (shifted > PIX_MAX) begin
            pix_c = 8'sd127;
            sat_c = 1'b1;
        end else if (shifted < PIX_MIN) begin
            pix_c = -8'sd128;
            sat_c = 1'b1;
        end
`ifdef RELU_EN
        // The clamp is applied after saturation and does not raise sat_flag.
        if (pix_c[7]) begin
            pix_c = 8'sd0;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            pix_out   <= 8'sd0;
            sat_flag  <= 1'b0;
        end else begin
            valid_out <= v2;
            sat_flag  <= v2 && sat_c;
            if (v2) begin
                pix_out <= pix_c;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_pipeline.sv
// tb_conv3x3_mac_pipeline: randomized scoreboard bench for conv3x3_mac_pipeline.
// Latency: expects each accepted window's pixel exactly 3 cycles after it is driven.
// Backpressure: none; the monitor samples every falling edge.
module tb_conv3x3_mac_pipeline;

    localparam int SHIFT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              win_valid;
    logic signed [7:0] win [9];
    logic              w_load;
    logic signed [15:0] bias_in;
    logic              w_valid;
    logic signed [7:0] w_data;
    logic              valid_out;
    logic signed [7:0] pix_out;
    logic              sat_flag;
    logic              weights_ok;
    logic              load_busy;

    conv3x3_mac_pipeline #(.SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .win_valid(win_valid),
        .win0(win[0]), .win1(win[1]), .win2(win[2]),
        .win3(win[3]), .win4(win[4]), .win5(win[5]),
        .win6(win[6]), .win7(win[7]), .win8(win[8]),
        .w_load(w_load), .bias_in(bias_in), .w_valid(w_valid), .w_data(w_data),
        .valid_out(valid_out), .pix_out(pix_out), .sat_flag(sat_flag),
        .weights_ok(weights_ok), .load_busy(load_busy)
    );

    typedef struct {
        int pix;
        bit sat;
        int stamp;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    // Reference state: what the engine should hold after the latest edge.
    int m_act [9];
    int m_sh  [9];
    int m_bias, m_sh_bias, m_cnt;
    bit m_ok, m_busy;
    int wset [9];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Convolution from first principles: signed dot product, floor division,
    // clip to the 8-bit range.
    function automatic exp_t ref_pix();
        exp_t   e;
        longint s;
        longint d;
        longint q;
        s = m_bias;
        for (int i = 0; i < 9; i++) s += longint'(int'(win[i])) * m_act[i];
        d = longint'(1) << SHIFT;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        e.sat = 1'b0;
        if (q > 127) begin
            q = 127; e.sat = 1'b1;
        end else if (q < -128) begin
            q = -128; e.sat = 1'b1;
        end
`ifdef RELU_EN
        if (q < 0) q = 0;
`else
`endif
        e.pix   = int'(q);
        e.stamp = 0;
        return e;
    endfunction

    function automatic void model_edge();
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                m_act[i] = 0;
                m_sh[i]  = 0;
            end
            m_bias = 0; m_sh_bias = 0; m_cnt = 0;
            m_ok = 1'b0; m_busy = 1'b0;
            // Windows not yet at the output by this edge are flushed.
            while (sb.size() > 0 && sb[$].stamp >= cyc - 3) void'(sb.pop_back());
            return;
        end
        if (win_valid && m_ok) begin
            e = ref_pix();
            e.stamp = cyc - 1;
            sb.push_back(e);
        end
        if (w_load) begin
            m_busy = 1'b1; m_cnt = 0; m_sh_bias = int'(bias_in);
        end else if (m_busy && w_valid) begin
            m_sh[m_cnt] = int'(w_data);
            if (m_cnt == 8) begin
                m_act  = m_sh;
                m_bias = m_sh_bias;
                m_ok   = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    // mode 0: no window, 1: all taps 10, 2: random taps
    task automatic set_win(input int mode);
        win_valid = (mode != 0);
        for (int i = 0; i < 9; i++) win[i] = (mode == 1) ? 8'sd10 : 8'($urandom);
    endtask

    task automatic win_const(input int t, input int n);
        for (int k = 0; k < n; k++) begin
            win_valid = 1'b1;
            for (int i = 0; i < 9; i++) win[i] = 8'(t);
            tick();
        end
        win_valid = 1'b0;
    endtask

    task automatic win_rand(input int n);
        for (int k = 0; k < n; k++) begin
            set_win(($urandom_range(3) == 0) ? 0 : 2);
            tick();
        end
        win_valid = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 9; i++) wset[i] = v;
    endtask

    task automatic load_set(input int b, input int stream, input bit gaps);
        w_load = 1'b1; bias_in = 16'(b); set_win(stream);
        tick();
        w_load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            while (gaps && $urandom_range(2) == 0) begin
                w_valid = 1'b0; set_win(stream); tick();
            end
            w_valid = 1'b1; w_data = 8'(wset[k]); set_win(stream);
            tick();
        end
        w_valid = 1'b0;
        win_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("weights_ok", int'(weights_ok), int'(m_ok));
            check("load_busy", int'(load_busy), int'(m_busy));
            while (sb.size() > 0 && sb[0].stamp + 3 < cyc) begin
                n_chk++; n_err++;
                $display("FAIL missing_pixel: window of cycle %0d got no valid_out, expected at cycle %0d",
                         sb[0].stamp, sb[0].stamp + 3);
                void'(sb.pop_front());
            end
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_valid: valid_out=1 pix_out=%0d expected no output (cycle %0d)",
                             pix_out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", cyc, mon_e.stamp + 3);
                    check("pix_out", int'(pix_out), mon_e.pix);
                    check("sat_flag", int'(sat_flag), int'(mon_e.sat));
                end
            end else begin
                check("sat_flag_idle", int'(sat_flag), 0);
            end
        end
    end

    initial begin
        rst = 1'b1; win_valid = 1'b0; w_load = 1'b0; w_valid = 1'b0;
        w_data = '0; bias_in = '0;
        for (int i = 0; i < 9; i++) win[i] = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("reset_valid_out", int'(valid_out), 0);
        check("reset_pix_out", int'(pix_out), 0);
        check("reset_sat_flag", int'(sat_flag), 0);
        check("reset_weights_ok", int'(weights_ok), 0);
        check("reset_load_busy", int'(load_busy), 0);

        // No weights yet: windows are dropped.
        win_const(10, 3);
        // Beats while idle are ignored.
        for (int k = 0; k < 4; k++) begin
            w_valid = 1'b1; w_data = 8'($urandom); tick();
        end
        w_valid = 1'b0;
        win_const(10, 2);

        fill(1);    load_set(0, 0, 0);   win_const(10, 4); win_rand(20);
        fill(127);  load_set(0, 0, 0);   win_const(127, 3);
        fill(-128); load_set(0, 0, 1);   win_const(127, 2); win_const(-128, 2);
        fill(-1);   load_set(0, 0, 0);   win_const(10, 2);
        load_set(100, 0, 0);             win_const(10, 2);
        fill(0);    load_set(-32768, 0, 0); win_const(5, 2);

        // Restart after 5 beats; the restart pulse coincides with a beat.
        w_load = 1'b1; bias_in = 16'sd7; tick(); w_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w_valid = 1'b1; w_data = 8'sd3; set_win(1); tick();
        end
        w_load = 1'b1; w_valid = 1'b1; w_data = 8'sd99; bias_in = -16'sd5; set_win(1); tick();
        w_load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            w_valid = 1'b1; w_data = 8'sd2; set_win(1); tick();
        end
        w_valid = 1'b0; win_rand(8);

        // Hot reload under a continuous stream of all-10 windows.
        fill(1); load_set(0, 1, 0);
        fill(2); load_set(0, 1, 1);
        win_const(10, 4);

        // Random weights and biases, windows streaming during loads.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 9; i++) wset[i] = int'($urandom_range(255)) - 128;
            load_set(int'($urandom_range(65535)) - 32768, 2, 1);
            win_rand(10);
        end

        // Reset with windows in flight, then dropped windows until reload.
        win_const(10, 3);
        rst = 1'b1; set_win(1); tick();
        rst = 1'b0; win_valid = 1'b0;
        win_const(10, 3);
        fill(1); load_set(0, 0, 0); win_const(10, 3);

        win_valid = 1'b0;
        repeat (6) tick();
        while (sb.size() > 0) begin
            n_chk++; n_err++;
            $display("FAIL drain: window of cycle %0d never produced output", sb[0].stamp);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
